// File: rtl/key_scan.sv
// key_scan: 4x4 matrix keypad scanner with debounce and a bus-readable key latch.
// Rows are driven low one at a time; the synchronised columns are sampled at the end of
// each row slot. A full 16-bit snapshot must repeat for DEBOUNCE_SCANS scans to count as stable.
module key_scan #(
    parameter int unsigned SCAN_END       = 20000 - 1,
    parameter int unsigned SCAN_WIDTH     = 20,
    parameter int unsigned DEBOUNCE_SCANS = 4,
    parameter int unsigned DB_WIDTH       = 3
) (
    input  logic        clk_from_bg,
    input  logic        rst_from_bg,
    input  logic [31:0] addr_from_bg,
    input  logic        we_from_bg,
    input  logic [31:0] wdata_from_bg,
    input  logic        rd_from_bg,
    output logic [31:0] rdata_2_bg,
    output logic [3:0]  key_row_2_soc,
    input  logic [3:0]  key_col_from_soc
);

    localparam logic [SCAN_WIDTH-1:0] SCAN_LAST = SCAN_WIDTH'(SCAN_END);
    localparam logic [DB_WIDTH-1:0]   DB_MAX    = DB_WIDTH'(DEBOUNCE_SCANS - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DOWN  = 2'd1,
        ST_MULTI = 2'd2
    } state_t;

    state_t                state_q, state_next;
    logic [3:0]            col_s1, col_s2;
    logic [3:0]            row_q;
    logic [SCAN_WIDTH-1:0] dwell_q;
    logic [15:0]           snap_q, prev_q, snap_next;
    logic [DB_WIDTH-1:0]   db_q, db_inc;
    logic [3:0]            code_q, key_idx;
    logic                  valid_q, ovf_q, scan_en_q;
    logic [1:0]            row_idx;
    logic                  sample_c, scan_done_c, stable_c, press_c, one_key_c;
    logic                  rd_key_c, wr_ctrl_c;
    logic                  unused_bits;

    assign unused_bits = ^{addr_from_bg[31:3], addr_from_bg[1:0], wdata_from_bg[31:2]};

    assign rd_key_c  = rd_from_bg && !addr_from_bg[2];
    assign wr_ctrl_c = we_from_bg && addr_from_bg[2];

    // Two-flop synchroniser on the asynchronous column inputs
    always_ff @(posedge clk_from_bg) begin
        if (rst_from_bg) begin
            col_s1 <= 4'hf;
            col_s2 <= 4'hf;
        end else begin
            col_s1 <= key_col_from_soc;
            col_s2 <= col_s1;
        end
    end

    // Row index, snapshot update and debounce decision for the current cycle
    always_comb begin
        row_idx = 2'd0;
        case (row_q)
            4'b1110: row_idx = 2'd0;
            4'b1101: row_idx = 2'd1;
            4'b1011: row_idx = 2'd2;
            4'b0111: row_idx = 2'd3;
            default: row_idx = 2'd0;
        endcase
        sample_c    = scan_en_q && (row_q != 4'hf) && (dwell_q == SCAN_LAST);
        scan_done_c = sample_c && (row_idx == 2'd3);
        snap_next   = snap_q;
        if (sample_c) begin
            snap_next[{row_idx, 2'b00} +: 4] = ~col_s2;
        end
        db_inc   = (db_q == DB_MAX) ? db_q : db_q + DB_WIDTH'(1);
        stable_c = scan_done_c && (snap_next == prev_q) && (db_inc == DB_MAX);
        one_key_c = (snap_next != 16'd0) && ((snap_next & (snap_next - 16'd1)) == 16'd0);
        key_idx = 4'd0;
        for (int i = 0; i < 16; i++) begin
            if (snap_next[i]) key_idx = 4'(i);
        end
    end

    // Row rotation, dwell counter, snapshot and debounce history
    always_ff @(posedge clk_from_bg) begin
        if (rst_from_bg || !scan_en_q) begin
            row_q   <= 4'hf;
            dwell_q <= '0;
            snap_q  <= '0;
            prev_q  <= '0;
            db_q    <= '0;
        end else if (row_q == 4'hf) begin
            row_q   <= 4'b1110;
            dwell_q <= '0;
        end else if (dwell_q == SCAN_LAST) begin
            row_q   <= {row_q[2:0], row_q[3]};
            dwell_q <= '0;
            snap_q  <= snap_next;
            if (scan_done_c) begin
                if (snap_next == prev_q) begin
                    db_q <= db_inc;
                end else begin
                    db_q   <= '0;
                    prev_q <= snap_next;
                end
            end
        end else begin
            dwell_q <= dwell_q + SCAN_WIDTH'(1);
        end
    end

    assign key_row_2_soc = row_q;

    // Stable-state FSM register
    always_ff @(posedge clk_from_bg) begin
        if (rst_from_bg) state_q <= ST_IDLE;
        else             state_q <= state_next;
    end

    // Stable-state transitions; a press event only leaves IDLE for a single key
    always_comb begin
        state_next = state_q;
        press_c    = 1'b0;
        if (!scan_en_q) begin
            state_next = ST_IDLE;
        end else if (stable_c) begin
            if (snap_next == 16'd0) begin
                state_next = ST_IDLE;
            end else if (one_key_c) begin
                state_next = ST_DOWN;
                press_c    = (state_q == ST_IDLE);
            end else begin
                state_next = ST_MULTI;
            end
        end
    end

    // Key latch, overflow flag and control register
    always_ff @(posedge clk_from_bg) begin
        if (rst_from_bg) begin
            code_q    <= '0;
            valid_q   <= 1'b0;
            ovf_q     <= 1'b0;
            scan_en_q <= 1'b1;
        end else begin
            if (press_c) begin
                valid_q <= 1'b1;
                if (!valid_q || rd_key_c) code_q <= key_idx;
            end else if (rd_key_c) begin
                valid_q <= 1'b0;
            end
            if (press_c && valid_q && !rd_key_c) ovf_q <= 1'b1;
            else if (wr_ctrl_c && wdata_from_bg[1]) ovf_q <= 1'b0;
            if (wr_ctrl_c) scan_en_q <= wdata_from_bg[0];
        end
    end

    // Read mux: bit 2 of the address selects STATUS over KEYDATA
    always_comb begin
        if (addr_from_bg[2]) begin
            rdata_2_bg = {28'd0, (state_q == ST_DOWN), valid_q, ovf_q, scan_en_q};
        end else begin
            rdata_2_bg = {valid_q, ovf_q, 26'd0, code_q};
        end
    end

endmodule

// File: tb/tb_key_scan.sv
// tb_key_scan: directed checks of key_scan with a short row dwell and a keypad model.
module tb_key_scan;

    logic        clk;
    logic        rst;
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    logic        rd;
    logic [31:0] rdata;
    logic [3:0]  rows;
    logic [3:0]  cols;
    logic [15:0] keys;

    int checks;
    int failures;

    localparam int unsigned SCAN = 16;

    key_scan #(
        .SCAN_END(3),
        .SCAN_WIDTH(20),
        .DEBOUNCE_SCANS(4),
        .DB_WIDTH(3)
    ) dut (
        .clk_from_bg(clk),
        .rst_from_bg(rst),
        .addr_from_bg(addr),
        .we_from_bg(we),
        .wdata_from_bg(wdata),
        .rd_from_bg(rd),
        .rdata_2_bg(rdata),
        .key_row_2_soc(rows),
        .key_col_from_soc(cols)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Keypad: a pressed key pulls its column low while its row is driven low
    always_comb begin
        cols = 4'hf;
        case (rows)
            4'b1110: cols = ~keys[3:0];
            4'b1101: cols = ~keys[7:4];
            4'b1011: cols = ~keys[11:8];
            4'b0111: cols = ~keys[15:12];
            default: cols = 4'hf;
        endcase
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic peek(input logic sel, output logic [31:0] val);
        addr = sel ? 32'h4 : 32'h0;
        #1 val = rdata;
    endtask

    task automatic bus_read(input logic sel, output logic [31:0] val);
        addr = sel ? 32'h4 : 32'h0;
        rd   = 1'b1;
        #1 val = rdata;
        @(negedge clk);
        rd = 1'b0;
    endtask

    task automatic bus_write(input logic sel, input logic [31:0] data);
        addr  = sel ? 32'h4 : 32'h0;
        wdata = data;
        we    = 1'b1;
        @(negedge clk);
        we = 1'b0;
    endtask

    task automatic wait_scans(input int n);
        repeat (n * SCAN) @(negedge clk);
    endtask

    // Leaves the bench at the negedge just before the edge that completes row 3
    task automatic wait_end_scan();
        int n;
        n = 0;
        while (rows !== 4'b1011 && n < 64) begin
            @(negedge clk);
            n++;
        end
        while (rows !== 4'b0111 && n < 64) begin
            @(negedge clk);
            n++;
        end
        check("scan_sync_timeout", 32'(n >= 64), 32'd0);
        repeat (3) @(negedge clk);
    endtask

    initial begin
        logic [31:0] v;
        checks   = 0;
        failures = 0;
        rst   = 1'b1;
        addr  = '0;
        we    = 1'b0;
        wdata = '0;
        rd    = 1'b0;
        keys  = '0;

        // Reset state
        repeat (3) @(negedge clk);
        check("reset_rows", 32'(rows), 32'hf);
        peek(1'b0, v); check("reset_keydata", v, 32'h0);
        peek(1'b1, v); check("reset_status", v, 32'h1);

        // Row sequence, four cycles per row
        rst = 1'b0;
        @(negedge clk);           check("row0", 32'(rows), 32'he);
        repeat (3) @(negedge clk); check("row0_hold", 32'(rows), 32'he);
        @(negedge clk);           check("row1", 32'(rows), 32'hd);
        repeat (4) @(negedge clk); check("row2", 32'(rows), 32'hb);
        repeat (4) @(negedge clk); check("row3", 32'(rows), 32'h7);
        repeat (4) @(negedge clk); check("row_wrap", 32'(rows), 32'he);

        // Single key 9 (row 2, column 1)
        keys[9] = 1'b1;
        wait_scans(6);
        peek(1'b0, v); check("key9_keydata", v, 32'h8000_0009);
        peek(1'b1, v); check("key9_status", v, 32'h0000_000d);
        bus_read(1'b0, v); check("key9_read_preclear", v, 32'h8000_0009);
        peek(1'b0, v); check("key9_after_read", v, 32'h0000_0009);
        keys[9] = 1'b0;
        wait_scans(6);
        peek(1'b1, v); check("release_status", v, 32'h1);

        // Bouncing key: toggles every scan, never stable
        for (int i = 0; i < 10; i++) begin
            keys[9] = ~keys[9];
            repeat (SCAN) @(negedge clk);
            peek(1'b1, v); check("bounce_status", v & 32'hc, 32'h0);
        end
        keys[9] = 1'b0;
        wait_scans(6);
        peek(1'b0, v); check("bounce_keydata", v, 32'h0000_0009);

        // Two presses without a read: first code kept, overflow set
        keys[9] = 1'b1; wait_scans(6);
        keys[9] = 1'b0; wait_scans(6);
        keys[5] = 1'b1; wait_scans(6);
        keys[5] = 1'b0; wait_scans(6);
        peek(1'b0, v); check("ovf_keydata", v, 32'hc000_0009);
        peek(1'b1, v); check("ovf_status", v, 32'h7);
        bus_write(1'b1, 32'h3);
        peek(1'b1, v); check("ovf_cleared_status", v, 32'h5);
        peek(1'b0, v); check("ovf_cleared_keydata", v, 32'h8000_0009);

        // Writes to KEYDATA have no effect
        bus_write(1'b0, 32'h0);
        peek(1'b1, v); check("kd_write_status", v, 32'h5);
        peek(1'b0, v); check("kd_write_keydata", v, 32'h8000_0009);

        // Read in the same cycle as the press event of key 5
        wait_end_scan();
        @(negedge clk);
        keys[5] = 1'b1;
        repeat (4) wait_end_scan();
        bus_read(1'b0, v); check("race_preclear", v, 32'h8000_0009);
        peek(1'b0, v); check("race_keydata", v, 32'h8000_0005);
        peek(1'b1, v); check("race_status", v, 32'hd);
        keys[5] = 1'b0;
        wait_scans(6);

        // Two keys together: MULTI, no event
        bus_read(1'b0, v); check("multi_pre_read", v, 32'h8000_0005);
        keys[9] = 1'b1;
        keys[5] = 1'b1;
        wait_scans(6);
        peek(1'b0, v); check("multi_keydata", v, 32'h0000_0005);
        peek(1'b1, v); check("multi_status", v, 32'h1);

        // Disable scanning, then re-enable from row 0
        bus_write(1'b1, 32'h0);
        @(negedge clk);
        check("disable_rows", 32'(rows), 32'hf);
        peek(1'b1, v); check("disable_status", v, 32'h0);
        repeat (20) @(negedge clk);
        check("disable_rows_hold", 32'(rows), 32'hf);
        keys = '0;
        bus_write(1'b1, 32'h1);
        @(negedge clk);
        check("reenable_row0", 32'(rows), 32'he);

        // Reset in the middle of debouncing a press
        keys[9] = 1'b1;
        wait_scans(2);
        rst = 1'b1;
        keys[9] = 1'b0;
        repeat (2) @(negedge clk);
        check("midreset_rows", 32'(rows), 32'hf);
        peek(1'b0, v); check("midreset_keydata", v, 32'h0);
        rst = 1'b0;
        wait_scans(6);
        peek(1'b0, v); check("midreset_no_event", v, 32'h0);
        peek(1'b1, v); check("midreset_status", v, 32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
